// File: rtl/conv_decoder_pkg.sv
// -----------------------------------------------------------------------------
// conv_decoder_pkg
// Shared definitions for the conv decoder input path: the scheduler FSM state
// encoding, the default pixel width and the signed pixel type.
// -----------------------------------------------------------------------------
package conv_decoder_pkg;

    localparam int DATA_W = 18;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        ISSUE,
        DONE
    } state_t;

endpackage

// File: rtl/conv_decoder_pos_counter.sv
// -----------------------------------------------------------------------------
// conv_decoder_pos_counter
// Nested raster-position counter over the padded feature map: col runs
// fastest, then row, then channel. It reports whether the current position is
// a padding position and whether it is the last position of the frame.
//
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  return all counters to position 0
//   advance  in  step to the next raster position
//   is_pad   out current position lies in the zero border
//   is_last  out current position is (CH-1, PH-1, PW-1)
// -----------------------------------------------------------------------------
module conv_decoder_pos_counter #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CH    = 1,
    parameter int PAD   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output logic is_pad,
    output logic is_last
);

    localparam int PW    = IMG_W + 2 * PAD;
    localparam int PH    = IMG_H + 2 * PAD;
    localparam int COL_W = $clog2(PW + 1);
    localparam int ROW_W = $clog2(PH + 1);
    localparam int CH_W  = $clog2(CH + 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q,  ch_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
            ch_d  = '0;
        end else if (advance) begin
            if (col_q == COL_W'(PW - 1)) begin
                col_d = '0;
                if (row_q == ROW_W'(PH - 1)) begin
                    row_d = '0;
                    // After the last position ch reaches CH; the next clear resets it.
                    ch_d  = ch_q + CH_W'(1);
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            ch_q  <= ch_d;
        end
    end

    // Compared as int so that PAD = 0 does not produce unsigned-vs-zero tests.
    always_comb begin
        is_pad  = (int'(row_q) < PAD) || (int'(row_q) >= PAD + IMG_H) ||
                  (int'(col_q) < PAD) || (int'(col_q) >= PAD + IMG_W);
        is_last = (int'(ch_q) == CH - 1) && (int'(row_q) == PH - 1) &&
                  (int'(col_q) == PW - 1);
    end

endmodule

// File: rtl/conv_decoder_input_scheduler.sv
// -----------------------------------------------------------------------------
// conv_decoder_input_scheduler
// Walks a stored feature map in raster order (col, row, channel) and hands it
// to the decoder input buffer one pixel per handshake, inserting zero pixels
// for the padding border. Interior pixels are read from memory using a
// running address counter; one frame runs per frame_start.
//
// Ports:
//   clk          in  clock
//   rst_n        in  asynchronous active-low reset
//   frame_start  in  start a frame (honoured only when idle)
//   dec_ready    in  decoder accepts a pixel this cycle
//   mem_rd_en    out memory read strobe
//   mem_addr     out memory read address (valid with mem_rd_en)
//   mem_rd_data  in  memory read data, one cycle after mem_rd_en
//   buf_start    out pixel-issue strobe (ISSUE state and dec_ready)
//   buf_pixel    out pixel value, valid with buf_start
//   busy         out high whenever not idle
//   frame_done   out one-cycle pulse after the last pixel handshake
// -----------------------------------------------------------------------------
module conv_decoder_input_scheduler #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int CH     = 1,
    parameter int PAD    = 1,
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     dec_ready,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] mem_rd_data,
    output logic                     buf_start,
    output logic signed [DATA_W-1:0] buf_pixel,
    output logic                     busy,
    output logic                     frame_done
);

    import conv_decoder_pkg::*;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_cnt_q, addr_cnt_d;
    logic signed [DATA_W-1:0]  pix_reg_q, pix_reg_d;
    logic                      pos_clear;
    logic                      pos_advance;
    logic                      is_pad;
    logic                      is_last;

    conv_decoder_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CH    (CH),
        .PAD   (PAD)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (pos_clear),
        .advance (pos_advance),
        .is_pad  (is_pad),
        .is_last (is_last)
    );

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        pix_reg_d   = pix_reg_q;
        pos_clear   = 1'b0;
        pos_advance = 1'b0;
        mem_rd_en   = 1'b0;
        buf_start   = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    pos_clear  = 1'b1;
                    addr_cnt_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (is_pad) begin
                    pix_reg_d = '0;
                    state_d   = ISSUE;
                end else begin
                    mem_rd_en = 1'b1;
                    state_d   = CAPT;
                end
            end
            CAPT: begin
                // Interior raster order equals linear memory order, so a plain
                // increment after each read yields the next interior address.
                pix_reg_d  = mem_rd_data;
                addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                state_d    = ISSUE;
            end
            ISSUE: begin
                buf_start = dec_ready;
                if (dec_ready) begin
                    pos_advance = 1'b1;
                    state_d     = is_last ? DONE : FETCH;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_cnt_q <= '0;
            pix_reg_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            pix_reg_q  <= pix_reg_d;
        end
    end

    assign mem_addr  = addr_cnt_q;
    assign buf_pixel = pix_reg_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_decoder_input_scheduler.sv
module tb_conv_decoder_input_scheduler;

    localparam int DW = 18;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: 4x4, CH=1, PAD=1
    logic                 fs_a, rdy_a, rd_en_a, bs_a, busy_a, done_a;
    logic [AW-1:0]        addr_a;
    logic signed [DW-1:0] rdata_a, pix_a;
    // Instance B: 2x2, CH=2, PAD=0
    logic                 fs_b, rdy_b, rd_en_b, bs_b, busy_b, done_b;
    logic [AW-1:0]        addr_b;
    logic signed [DW-1:0] rdata_b, pix_b;

    logic signed [DW-1:0] mem_a [0:15];
    logic signed [DW-1:0] mem_b [0:7];

    logic signed [DW-1:0] q_pix_a [$];
    int                   q_addr_a [$];
    logic signed [DW-1:0] q_pix_b [$];
    int                   q_addr_b [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_b, hs_b;

    conv_decoder_input_scheduler #(
        .IMG_W(4), .IMG_H(4), .CH(1), .PAD(1), .DATA_W(DW), .ADDR_W(AW)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (fs_a),
        .dec_ready   (rdy_a),
        .mem_rd_en   (rd_en_a),
        .mem_addr    (addr_a),
        .mem_rd_data (rdata_a),
        .buf_start   (bs_a),
        .buf_pixel   (pix_a),
        .busy        (busy_a),
        .frame_done  (done_a)
    );

    conv_decoder_input_scheduler #(
        .IMG_W(2), .IMG_H(2), .CH(2), .PAD(0), .DATA_W(DW), .ADDR_W(AW)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (fs_b),
        .dec_ready   (rdy_b),
        .mem_rd_en   (rd_en_b),
        .mem_addr    (addr_b),
        .mem_rd_data (rdata_b),
        .buf_start   (bs_b),
        .buf_pixel   (pix_b),
        .busy        (busy_b),
        .frame_done  (done_b)
    );

    // Synchronous-read memories: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en_a) rdata_a <= mem_a[addr_a[3:0]];
        if (rd_en_b) rdata_b <= mem_b[addr_b[2:0]];
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_a();
        int a;
        a = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (r < 1 || r >= 5 || c < 1 || c >= 5) begin
                    q_pix_a.push_back('0);
                end else begin
                    q_addr_a.push_back(a);
                    q_pix_a.push_back(mem_a[a]);
                    a++;
                end
            end
        end
    endtask

    task automatic push_b();
        for (int i = 0; i < 8; i++) begin
            q_addr_b.push_back(i);
            q_pix_b.push_back(mem_b[i]);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (bs_a) begin
            if (q_pix_a.size() == 0) check("a_extra_pixel", 1, 0);
            else check("a_pixel", pix_a, q_pix_a.pop_front());
        end
        if (rd_en_a) begin
            if (q_addr_a.size() == 0) check("a_extra_read", 1, 0);
            else check("a_addr", addr_a, q_addr_a.pop_front());
        end
        if (bs_b) begin
            if (q_pix_b.size() == 0) check("b_extra_pixel", 1, 0);
            else check("b_pixel", pix_b, q_pix_b.pop_front());
        end
        if (rd_en_b) begin
            if (q_addr_b.size() == 0) check("b_extra_read", 1, 0);
            else check("b_addr", addr_b, q_addr_b.pop_front());
        end
    end

    task automatic run_a(input int stall_px, input int stall_len, input int stall_val,
                         input int mid_fs_cyc, input bit done_fs, input int abort_hs,
                         input int exp_cycles);
        int cyc, hs, pend;
        bit fin, low;
        cyc = 0; hs = 0; pend = 0; fin = 0;
        push_a();
        @(posedge clk); #1 fs_a = 1'b1; rdy_a = 1'b1;
        @(posedge clk); #1 fs_a = 1'b0;
        check("a_busy_at_fetch", busy_a, 1);
        while (!fin) begin
            low = (pend > 0);
            if (low) pend--;
            rdy_a = !low;
            fs_a  = (cyc == mid_fs_cyc) || (done_fs && done_a);
            #1;
            if (abort_hs > 0 && bs_a && hs == abort_hs - 1) begin
                rst_n = 1'b0;
                #1;
                check("rst_rd_en", rd_en_a, 0);
                check("rst_addr", addr_a, 0);
                check("rst_buf_start", bs_a, 0);
                check("rst_buf_pixel", pix_a, 0);
                check("rst_busy", busy_a, 0);
                check("rst_done", done_a, 0);
                q_pix_a.delete();
                q_addr_a.delete();
                fs_a = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("rst_no_done", done_a, 0);
                end
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("after_rst_no_done", done_a, 0);
                end
                return;
            end
            if (low && pend < stall_len) begin
                check("stall_no_buf_start", bs_a, 0);
                check("stall_pixel_held", pix_a, stall_val);
            end
            @(negedge clk);
            if (done_a) begin
                fin = 1'b1;
            end else begin
                if (bs_a) begin
                    hs++;
                    if (hs == stall_px - 1 && stall_len > 0) pend = stall_len + 2;
                end
                @(posedge clk); #1;
                cyc++;
                if (cyc > 3000) begin
                    check("a_timeout", 0, 1);
                    fin = 1'b1;
                end
            end
        end
        check("a_frame_cycles", cyc, exp_cycles);
        check("a_handshakes", hs, 36);
        check("a_busy_in_done", busy_a, 1);
        check("a_pix_queue_left", q_pix_a.size(), 0);
        check("a_addr_queue_left", q_addr_a.size(), 0);
        @(posedge clk); #1 fs_a = 1'b0;
        check("a_done_one_cycle", done_a, 0);
        check("a_idle_after_done", busy_a, 0);
        repeat (3) begin
            @(negedge clk);
            check("a_stays_idle", busy_a, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fs_a = 1'b0; rdy_a = 1'b0;
        fs_b = 1'b0; rdy_b = 1'b0;
        for (int i = 0; i < 16; i++) mem_a[i] = DW'(i + 1);
        for (int i = 0; i < 8; i++)  mem_b[i] = DW'(10 * (i + 1));
        #1;
        check("reset_rd_en", rd_en_a, 0);
        check("reset_addr", addr_a, 0);
        check("reset_buf_start", bs_a, 0);
        check("reset_buf_pixel", pix_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_b_busy", busy_b, 0);
        #20;
        @(negedge clk) rst_n = 1'b1;

        // Baseline frame, dec_ready always high
        run_a(0, 0, 0, -1, 1'b0, 0, 88);
        // 5-cycle stall on the 10th pixel (value mem[2] = 3)
        run_a(10, 5, 3, -1, 1'b0, 0, 93);
        // frame_start mid-frame and in the DONE cycle
        run_a(0, 0, 0, 20, 1'b1, 0, 88);
        // reset during the 20th ISSUE, then a clean restart
        run_a(0, 0, 0, -1, 1'b0, 20, 0);
        run_a(0, 0, 0, -1, 1'b0, 0, 88);
        // extreme signed values pass bit-exact
        mem_a[5]  = -18'sd131072;
        mem_a[10] = 18'sd131071;
        run_a(0, 0, 0, -1, 1'b0, 0, 88);

        // PAD=0, CH=2, 2x2: eight interior reads, no zero pixels
        push_b();
        @(posedge clk); #1 fs_b = 1'b1; rdy_b = 1'b1;
        @(posedge clk); #1 fs_b = 1'b0;
        cyc_b = 0; hs_b = 0;
        while (!done_b && cyc_b < 500) begin
            @(negedge clk);
            if (bs_b) hs_b++;
            @(posedge clk); #1;
            cyc_b++;
        end
        check("b_frame_cycles", cyc_b, 24);
        check("b_handshakes", hs_b, 8);
        check("b_pix_queue_left", q_pix_b.size(), 0);
        check("b_addr_queue_left", q_addr_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_decoder_input_scheduler.md
# conv_decoder_input_scheduler

Sequencer that walks a stored feature map in raster order and feeds it, one pixel per handshake, into the conv decoder input buffer. It reads interior pixels from the feature-map memory, inserts zero-valued border pixels for padding, and issues each pixel with a single-cycle `buf_start` strobe. One instance sits between the feature-map memory and the decoder input buffer; it runs one frame per `frame_start`.

## Interface
Parameters:
- `IMG_W`, default 28: unpadded image width.
- `IMG_H`, default 28: unpadded image height.
- `CH`, default 1: channel count.
- `PAD`, default 1: zero border width on every side; 0 is legal.
- `DATA_W`, default 18: signed pixel width.
- `ADDR_W`, default 10: memory address width; must satisfy 2^ADDR_W ≥ CH·IMG_H·IMG_W.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse that starts a frame; honoured only in IDLE.
- `dec_ready` in 1: decoder can accept a pixel this cycle.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_W: read address, valid while `mem_rd_en` is high.
- `mem_rd_data` in DATA_W signed: read data, valid exactly one cycle after `mem_rd_en`.
- `buf_start` out 1: pixel-issue strobe to the input buffer.
- `buf_pixel` out DATA_W signed: pixel value, valid whenever `buf_start` is high.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse after the last pixel is issued.

## Operation
- Padded dimensions: PW = IMG_W + 2·PAD and PH = IMG_H + 2·PAD. One frame issues CH·PH·PW pixels. `col` increments fastest, then `row`, then `ch`.
- A position is padding if `row` < PAD, `row` ≥ PAD+IMG_H, `col` < PAD, or `col` ≥ PAD+IMG_W.
- Address generation uses a running counter `addr_cnt`, not a multiplier. It clears at frame start and increments after each interior read. Raster order of interior pixels equals linear memory order: address = ch·IMG_H·IMG_W + (row−PAD)·IMG_W + (col−PAD).
- States:
  - IDLE: `frame_start`=1 clears `row`, `col`, `ch` and `addr_cnt`, then goes to FETCH.
  - FETCH, padding position: `pix_reg` ← 0, then go to ISSUE.
  - FETCH, interior position: drive `mem_rd_en`=1 and `mem_addr`=`addr_cnt` combinationally, then go to CAPT.
  - CAPT: `pix_reg` ← `mem_rd_data`, `addr_cnt` += 1, then go to ISSUE.
  - ISSUE: `buf_start` = `dec_ready` (combinational), `buf_pixel` = `pix_reg`. The state holds while `dec_ready`=0. On `dec_ready`=1, advance the position; go to DONE if this was the last position, else to FETCH.
  - DONE: `frame_done`=1 for one cycle, then go to IDLE.
- `frame_start` while busy is ignored; it is not queued.
- `dec_ready` is sampled only in ISSUE.
- Counter wrap: `col` wraps PW−1→0 and increments `row`. `row` wraps PH−1→0 and increments `ch`. The last position is (CH−1, PH−1, PW−1).

## Timing
- Reset values:
  - state IDLE.
  - `mem_rd_en`=0, `mem_addr`=0.
  - `buf_start`=0, `buf_pixel`=0.
  - `busy`=0, `frame_done`=0.
  - all counters 0, `pix_reg`=0.
- Latency:
  - `frame_start` at cycle t puts FETCH at t+1.
  - Interior pixel: 3 cycles (FETCH, CAPT, ISSUE) with `dec_ready` held high.
  - Padding pixel: 2 cycles.
  - `frame_done` appears the cycle after the final handshake.
- Every stall cycle in ISSUE adds exactly one cycle. `buf_pixel` is stable throughout a stall.
- At most one `buf_start` per pixel. `buf_start` never occurs outside ISSUE.
- Reset asserted mid-frame: outputs return to reset values asynchronously. No `frame_done` is produced, and the next frame starts from position 0.
- `frame_start` in the same cycle as `frame_done`: ignored, because the state is still DONE.

## Structure
- Shared package `conv_decoder_pkg`:
  - state enum (IDLE, FETCH, CAPT, ISSUE, DONE).
  - `DATA_W` constant.
  - signed pixel typedef.
- Sub-module `conv_decoder_pos_counter`: nested col/row/ch counter with `clear` and `advance` inputs and `is_pad` and `is_last` outputs.
- The top level holds the FSM, `addr_cnt` and `pix_reg`.

## Test plan
- 4×4 image, CH=1, PAD=1, memory[i]=i+1, `dec_ready`=1: 36 `buf_start` pulses. The first 7 pixels are 0. The 8th is 1, and the interior reads addresses 0..15 in order. `frame_done` comes 1 cycle after the 36th pulse; total 2·20+3·16=88 cycles from FETCH entry.
- Same frame with `dec_ready` low for 5 cycles on the 10th pixel: `buf_pixel` is held and there is no `buf_start` during the stall. The sequence is identical and the frame takes 93 cycles.
- PAD=0, CH=2, 2×2 image: addresses 0..7 are read, 8 pixels are issued, and no zero pixels appear.
- `frame_start` pulsed mid-frame and again in the DONE cycle: both ignored. The pixel count stays 36 and `busy` drops only after `frame_done`.
- `rst_n` low during the 20th ISSUE: all outputs are 0 immediately and no `frame_done` appears. A new `frame_start` restarts from address 0 with zero-pixel first.
- Negative data (memory = −131072 and 131071): passed bit-exact through `buf_pixel`.
